// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave controller.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} spi_state_e;

  localparam int                    SPI_WORD_W = 8;
  localparam logic [SPI_WORD_W-1:0] SPI_DUMMY  = 8'hFF;
endpackage

// File: rtl/spi_slave_shifter.sv
// N-bit shift register: parallel load, shift-left with serial in, MSB out.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int N = SPI_WORD_W
) (
  input  logic         clk_c,
  input  logic         reset_r,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         shift_en,
  input  logic         sin,
  output logic [N-1:0] q,
  output logic         sout
);
  logic [N-1:0] q_r;

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r)       q_r <= '0;
    else if (load)     q_r <= load_data;
    else if (shift_en) q_r <= {q_r[N-2:0], sin};
  end

  assign q    = q_r;
  assign sout = q_r[N-1];
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave: oversampled pins, CS framing, TX holding register, RX word.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int           N     = SPI_WORD_W,
  parameter logic [N-1:0] DUMMY = N'(SPI_DUMMY)
) (
  input  logic         clk_c,
  input  logic         reset_r,
  input  logic         sclk_i,
  input  logic         cs_n_i,
  input  logic         mosi_i,
  output logic         miso_o,
  input  logic [N-1:0] tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic [N-1:0] rx_data_o,
  output logic         rx_valid_o,
  output logic         busy_o,
  output logic         underrun_o,
  output logic         abort_o
);
  localparam int             CW       = $clog2(N+1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N-1);
  localparam logic [CW-1:0]  CNT_N    = CW'(N);

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  // mosi gets only two stages so it lines up with sclk_s2
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
      {cs_s1, cs_s2, cs_s3}       <= 3'b111;
      {mosi_s1, mosi_s2}          <= 2'b00;
    end else begin
      {sclk_s1, sclk_s2, sclk_s3} <= {sclk_i, sclk_s1, sclk_s2};
      {cs_s1, cs_s2, cs_s3}       <= {cs_n_i, cs_s1, cs_s2};
      {mosi_s1, mosi_s2}          <= {mosi_i, mosi_s1};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;

  spi_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          hold_full, miso_q;
  logic [N-1:0]  hold_data, load_word, sh_q;
  logic          frame_start, shift_en, bit_done, abort_evt, tx_accept, sh_sout;

  assign frame_start = (state == IDLE) & cs_fall;
  assign shift_en    = (state == XFER) & sclk_rise;
  assign bit_done    = shift_en & (cnt == CNT_LAST);
  assign abort_evt   = (state == XFER) & cs_rise & ~bit_done;
  assign tx_accept   = tx_valid_i & ~hold_full;
  assign load_word   = hold_full ? hold_data : DUMMY;

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cs_fall) state_nxt = XFER;
      // a CS release coinciding with the last edge still completes the word
      XFER: if (bit_done)     state_nxt = cs_rise ? IDLE : DONE;
            else if (cs_rise) state_nxt = IDLE;
      DONE: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    miso_o = (state == XFER) & miso_q;
  end

  spi_slave_shifter #(.N(N)) u_shifter (
    .clk_c     (clk_c),
    .reset_r   (reset_r),
    .load      (frame_start),
    .load_data (load_word),
    .shift_en  (shift_en),
    .sin       (mosi_s2),
    .q         (sh_q),
    .sout      (sh_sout)
  );

  // holding register: a word arriving in the frame-start cycle refills it
  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      hold_full <= (hold_full & ~frame_start) | tx_accept;
      if (tx_accept) hold_data <= tx_data_i;
    end
  end
  assign tx_ready_o = ~hold_full;

  always_ff @(posedge clk_c or posedge reset_r) begin
    if (reset_r) begin
      cnt        <= '0;
      miso_q     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      if (frame_start)   cnt <= '0;
      else if (shift_en) cnt <= cnt + 1'b1;

      if (frame_start)
        miso_q <= load_word[N-1];
      else if ((state == XFER) & sclk_fall & (cnt != '0) & (cnt < CNT_N))
        miso_q <= sh_sout;

      if (bit_done) rx_data_o <= {sh_q[N-2:0], mosi_s2};
      rx_valid_o <= bit_done;
      underrun_o <= frame_start & ~hold_full;
      abort_o    <= abort_evt;
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: vector table plus hand-built corner sequences.
module tb_spi_slave_ctrl;
  localparam int N = 8;

  logic         clk_c = 1'b0;
  logic         reset_r;
  logic         sclk_i, cs_n_i, mosi_i;
  logic         miso_o;
  logic [N-1:0] tx_data_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic [N-1:0] rx_data_o;
  logic         rx_valid_o, busy_o, underrun_o, abort_o;

  spi_slave_ctrl #(.N(N)) dut (
    .clk_c      (clk_c),
    .reset_r    (reset_r),
    .sclk_i     (sclk_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o),
    .abort_o    (abort_o)
  );

  always #5 clk_c = ~clk_c;

  int n_chk = 0, n_fail = 0;
  int rxv_tot = 0, und_tot = 0, abt_tot = 0;

  always @(negedge clk_c) begin
    if (rx_valid_o) rxv_tot++;
    if (underrun_o) und_tot++;
    if (abort_o)    abt_tot++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_c);
  endtask

  task automatic host_push(input logic [N-1:0] d, output logic acc);
    @(negedge clk_c);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    acc        = tx_ready_o;
    @(negedge clk_c);
    tx_valid_i = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk_c);
    cs_n_i = 1'b0;
    tick(8);
  endtask

  // one mode-0 bit at clk_c/8: drive mosi low-phase, sample miso before the rising edge
  task automatic spi_bit(input logic m, output logic s);
    mosi_i = m;
    tick(4);
    s = miso_o;
    sclk_i = 1'b1;
    tick(4);
    sclk_i = 1'b0;
  endtask

  task automatic cs_high();
    tick(4);
    cs_n_i = 1'b1;
    tick(6);
  endtask

  task automatic run_frame(input logic [15:0] mosi, input int nbits, output logic [15:0] cap);
    logic s;
    cap = '0;
    cs_low();
    chk("start_busy", busy_o, 1);
    chk("start_tx_ready", tx_ready_o, 1);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi[nbits-1-i], s);
      cap = {cap[14:0], s};
    end
    tick(4);
    chk("busy_before_release", busy_o, 1);
    cs_n_i = 1'b1;
    tick(6);
    chk("busy_after_release", busy_o, 0);
  endtask

  typedef struct {
    logic        queued;
    logic [7:0]  tx;
    logic [15:0] mosi;
    int          nbits;
    logic [15:0] exp_miso;
    logic [7:0]  exp_rx;
    int          exp_rxv;
    int          exp_und;
    int          exp_abt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic        acc, s;
    logic [15:0] cap;
    int          r0, u0, a0;

    vecs[0] = '{1'b1, 8'hA5, 16'h003C, 8,  16'h00A5, 8'h3C, 1, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 16'h0081, 8,  16'h00FF, 8'h81, 1, 1, 0};
    vecs[2] = '{1'b1, 8'hF0, 16'h0016, 5,  16'h001E, 8'h81, 0, 0, 1};
    vecs[3] = '{1'b1, 8'h33, 16'h005A, 8,  16'h0033, 8'h5A, 1, 0, 0};
    vecs[4] = '{1'b1, 8'h96, 16'h0C7A, 12, 16'h0960, 8'hC7, 1, 0, 0};

    reset_r = 1'b1; sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
    tx_data_i = '0; tx_valid_i = 1'b0;
    tick(3);
    chk("reset_outputs", {miso_o, tx_ready_o, rx_valid_o, busy_o, underrun_o, abort_o}, 6'b010000);
    chk("reset_rx_data", rx_data_o, 0);
    reset_r = 1'b0;
    tick(4);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].queued) begin
        host_push(vecs[v].tx, acc);
        chk("push_accepted", acc, 1);
        chk("push_ready_low", tx_ready_o, 0);
      end
      r0 = rxv_tot; u0 = und_tot; a0 = abt_tot;
      run_frame(vecs[v].mosi, vecs[v].nbits, cap);
      chk($sformatf("v%0d_miso", v), cap, vecs[v].exp_miso);
      chk($sformatf("v%0d_rx_data", v), rx_data_o, vecs[v].exp_rx);
      chk($sformatf("v%0d_rx_valid_cnt", v), rxv_tot - r0, vecs[v].exp_rxv);
      chk($sformatf("v%0d_underrun_cnt", v), und_tot - u0, vecs[v].exp_und);
      chk($sformatf("v%0d_abort_cnt", v), abt_tot - a0, vecs[v].exp_abt);
      tick(4);
    end

    // host writes during a frame; a second write must stall until the next frame
    cs_low();
    chk("mid_ready_empty", tx_ready_o, 1);
    host_push(8'h11, acc);
    chk("mid_push1_acc", acc, 1);
    chk("mid_ready_low", tx_ready_o, 0);
    host_push(8'h22, acc);
    chk("mid_push2_rejected", acc, 0);
    for (int i = 0; i < N; i++) spi_bit(1'b0, s);
    cs_high();
    chk("mid_rx_zero", rx_data_o, 0);
    r0 = rxv_tot;
    run_frame(16'h0042, 8, cap);
    chk("next_frame_miso", cap, 16'h0011);
    chk("next_frame_rx", rx_data_o, 8'h42);
    chk("next_frame_rxv", rxv_tot - r0, 1);
    tick(4);

    // reset in the middle of a frame
    host_push(8'hEE, acc);
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, s);
    @(negedge clk_c);
    reset_r = 1'b1;
    #1;
    chk("midrst_outputs", {miso_o, tx_ready_o, rx_valid_o, busy_o, underrun_o, abort_o}, 6'b010000);
    chk("midrst_rx_data", rx_data_o, 0);
    cs_n_i = 1'b1; sclk_i = 1'b0;
    tick(2);
    reset_r = 1'b0;
    tick(4);
    host_push(8'hC3, acc);
    chk("postrst_push", acc, 1);
    r0 = rxv_tot; u0 = und_tot;
    run_frame(16'h003C, 8, cap);
    chk("postrst_miso", cap, 16'h00C3);
    chk("postrst_rx", rx_data_o, 8'h3C);
    chk("postrst_rxv", rxv_tot - r0, 1);
    chk("postrst_underrun", und_tot - u0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
